// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: pixel type and counter-width helper.
// The line delay buffer and the downstream window stage both import this.
package img_pkg;

    localparam int PIX_WIDTH = 8;

    typedef logic [PIX_WIDTH-1:0] pixel_t;

    // Width of an index counter covering 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_delay_buffer_line_ram.sv
// One image line of storage: asynchronous read port, synchronous write port.
module line_ram
    import img_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [idx_w(DEPTH)-1:0]  i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [idx_w(DEPTH)-1:0]  i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    // Contents are deliberately not reset; the owner masks unwritten rows.
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: one word per enabled clock.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/line_delay_buffer.sv
// Row-delay store ahead of the sliding-window stage. Each incoming pixel is
// presented together with the pixels in the same column from the previous
// WIN_SIZE-1 rows; rows not yet written in the current frame read as zero.
module line_delay_buffer
    import img_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int WIN_SIZE     = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  pixel_valid,
    input  logic [DATA_WIDTH-1:0]                 pixel_in,
    input  logic                                  sof,
    output logic [WIN_SIZE-2:0][DATA_WIDTH-1:0]   line_out,
    output logic [WIN_SIZE-2:0]                   line_valid,
    output logic                                  lines_ready,
    output logic [idx_w(IMAGE_WIDTH)-1:0]         col_idx,
    output logic [idx_w(IMAGE_HEIGHT)-1:0]        row_idx,
    output logic                                  eol,
    output logic                                  eof
);

    localparam int NL = WIN_SIZE - 1;
    localparam int CW = idx_w(IMAGE_WIDTH);
    localparam int RW = idx_w(IMAGE_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

    logic [CW-1:0]                 r_col;
    logic [RW-1:0]                 r_row;
    logic [NL-1:0]                 r_lv;
    logic                          r_eol;
    logic                          r_eof;
    logic [CW-1:0]                 w_wr_col;
    logic [NL-1:0][DATA_WIDTH-1:0] w_rd;
    logic [NL-1:0][DATA_WIDTH-1:0] w_wd;

    // A frame start always lands its pixel in column 0.
    assign w_wr_col = sof ? '0 : r_col;

    // Write cascade: line 0 takes the new pixel, each deeper line takes the
    // pre-edge contents of the line above it (read-before-write).
    always_comb begin
        w_wd    = '0;
        w_wd[0] = pixel_in;
        for (int k = 1; k < NL; k++) begin
            w_wd[k] = w_rd[k-1];
        end
    end

    for (genvar g = 0; g < NL; g++) begin : g_line
        line_ram #(
            .DEPTH (IMAGE_WIDTH),
            .WIDTH (DATA_WIDTH)
        ) u_line (
            .clk     (clk),
            .i_we    (pixel_valid),
            .i_waddr (w_wr_col),
            .i_wdata (w_wd[g]),
            .i_raddr (r_col),
            .o_rdata (w_rd[g])
        );
    end

    // Position counters, row-validity mask and end-of-line/frame pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
            r_lv  <= '0;
            r_eol <= 1'b0;
            r_eof <= 1'b0;
        end else begin
            r_eol <= 1'b0;
            r_eof <= 1'b0;
            if (pixel_valid) begin
                if (sof) begin
                    r_col <= CW'(1);
                    r_row <= '0;
                    r_lv  <= '0;
                end else if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_eol <= 1'b1;
                    if (r_row == ROW_LAST) begin
                        r_row <= '0;
                        r_lv  <= '0;
                        r_eof <= 1'b1;
                    end else begin
                        r_row <= r_row + RW'(1);
                        r_lv  <= NL'({r_lv, 1'b1});
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    // Hide lines that have not been filled in the current frame.
    always_comb begin
        line_out = '0;
        for (int k = 0; k < NL; k++) begin
            line_out[k] = r_lv[k] ? w_rd[k] : '0;
        end
    end

    assign line_valid  = r_lv;
    assign lines_ready = &r_lv;
    assign col_idx     = r_col;
    assign row_idx     = r_row;
    assign eol         = r_eol;
    assign eof         = r_eof;

endmodule

// File: tb/tb_line_delay_buffer.sv
// Bench for line_delay_buffer with a 4x4 image and a 3-row window.
module tb_line_delay_buffer;
    import img_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WS = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pixel_valid = 1'b0;
    pixel_t           pixel_in = '0;
    logic             sof = 1'b0;
    logic [1:0][7:0]  line_out;
    logic [1:0]       line_valid;
    logic             lines_ready;
    logic [1:0]       col_idx;
    logic [1:0]       row_idx;
    logic             eol;
    logic             eof;

    int total = 0;
    int bad   = 0;
    int eol_seen = 0;

    // Reference model: the picture as written in the current frame, and the
    // position of the next pixel.
    pixel_t pix [H][W];
    int     m_col = 0;
    int     m_row = 0;
    logic   m_eol = 1'b0;
    logic   m_eof = 1'b0;

    line_delay_buffer #(
        .DATA_WIDTH   (8),
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .WIN_SIZE     (WS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_valid (pixel_valid),
        .pixel_in    (pixel_in),
        .sof         (sof),
        .line_out    (line_out),
        .line_valid  (line_valid),
        .lines_ready (lines_ready),
        .col_idx     (col_idx),
        .row_idx     (row_idx),
        .eol         (eol),
        .eof         (eof)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Row k+1 above exists once the current frame has passed k+1 rows.
    function automatic logic [1:0] exp_lv();
        logic [1:0] v;
        v[0] = (m_row >= 1);
        v[1] = (m_row >= 2);
        return v;
    endfunction

    function automatic logic [7:0] exp_line(input int k);
        if (m_row >= k + 1) return pix[m_row-k-1][m_col];
        return 8'h00;
    endfunction

    task automatic check_model();
        logic [1:0] lv;
        lv = exp_lv();
        chk("col_idx", 32'(col_idx), 32'(m_col));
        chk("row_idx", 32'(row_idx), 32'(m_row));
        chk("line_valid", 32'(line_valid), 32'(lv));
        chk("lines_ready", 32'(lines_ready), 32'(&lv));
        chk("eol", 32'(eol), 32'(m_eol));
        chk("eof", 32'(eof), 32'(m_eof));
        chk("line_out0", 32'(line_out[0]), 32'(exp_line(0)));
        chk("line_out1", 32'(line_out[1]), 32'(exp_line(1)));
    endtask

    task automatic model_step(input logic r, input logic v, input logic s, input pixel_t p);
        if (r) begin
            m_col = 0;
            m_row = 0;
            m_eol = 1'b0;
            m_eof = 1'b0;
        end else begin
            m_eol = 1'b0;
            m_eof = 1'b0;
            if (v) begin
                if (s) begin
                    pix[0][0] = p;
                    m_col = 1;
                    m_row = 0;
                end else begin
                    pix[m_row][m_col] = p;
                    if (m_col == W - 1) begin
                        m_col = 0;
                        m_eol = 1'b1;
                        if (m_row == H - 1) begin
                            m_row = 0;
                            m_eof = 1'b1;
                        end else begin
                            m_row++;
                        end
                    end else begin
                        m_col++;
                    end
                end
            end
        end
    endtask

    // Drive one cycle: inputs just after a rising edge, outputs checked on the
    // falling edge, model advanced at the rising edge.
    task automatic cyc(input logic r, input logic v, input logic s, input pixel_t p, input logic do_chk);
        rst = r;
        pixel_valid = v;
        sof = s;
        pixel_in = p;
        @(negedge clk);
        if (do_chk) check_model();
        if (eol === 1'b1) eol_seen++;
        @(posedge clk);
        model_step(r, v, s, p);
        #1;
    endtask

    initial begin
        int saved_col;
        int saved_row;

        // Reset, then check the reset state.
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("rst_col", 32'(col_idx), 32'd0);
        chk("rst_row", 32'(row_idx), 32'd0);
        chk("rst_lv", 32'(line_valid), 32'd0);
        chk("rst_ready", 32'(lines_ready), 32'd0);
        chk("rst_eol", 32'(eol), 32'd0);
        chk("rst_eof", 32'(eof), 32'd0);

        // Continuous ramp 0..15 starting with a frame start.
        for (int i = 0; i < 16; i++) begin
            rst = 1'b0;
            pixel_valid = 1'b1;
            sof = (i == 0);
            pixel_in = pixel_t'(i);
            @(negedge clk);
            check_model();
            if (i == 6) begin
                chk("ramp_r1c2_l0", 32'(line_out[0]), 32'd2);
                chk("ramp_r1c2_l1", 32'(line_out[1]), 32'd0);
                chk("ramp_r1c2_lv", 32'(line_valid), 32'b01);
            end
            if (i == 10) begin
                chk("ramp_r2c2_l0", 32'(line_out[0]), 32'd6);
                chk("ramp_r2c2_l1", 32'(line_out[1]), 32'd2);
                chk("ramp_r2c2_ready", 32'(lines_ready), 32'd1);
            end
            @(posedge clk);
            model_step(1'b0, 1'b1, (i == 0), pixel_t'(i));
            #1;
        end

        // Frame wrap: eof pulse, and the next pixel starts a fresh frame.
        rst = 1'b0;
        pixel_valid = 1'b1;
        sof = 1'b0;
        pixel_in = 8'd16;
        @(negedge clk);
        chk("wrap_eof", 32'(eof), 32'd1);
        chk("wrap_col", 32'(col_idx), 32'd0);
        chk("wrap_row", 32'(row_idx), 32'd0);
        chk("wrap_lv", 32'(line_valid), 32'd0);
        chk("wrap_line_out", 32'(line_out), 32'd0);
        @(posedge clk);
        model_step(1'b0, 1'b1, 1'b0, 8'd16);
        #1;

        // Same ramp with a gap every other cycle; eol must pulse four times.
        eol_seen = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, (i % 2 == 0), (i == 0), pixel_t'(i / 2), 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("gap_eol_count", 32'(eol_seen), 32'd4);

        // Frame start in the middle of row 2.
        cyc(1'b0, 1'b1, 1'b1, 8'd100, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, pixel_t'(100 + i), 1'b1);
        end
        chk("pre_sof_col", 32'(col_idx), 32'd1);
        chk("pre_sof_row", 32'(row_idx), 32'd2);
        cyc(1'b0, 1'b1, 1'b1, 8'd200, 1'b1);
        chk("midsof_col", 32'(col_idx), 32'd1);
        chk("midsof_row", 32'(row_idx), 32'd0);
        chk("midsof_lv", 32'(line_valid), 32'd0);
        chk("midsof_eol", 32'(eol), 32'd0);

        // Frame start without a valid pixel changes nothing.
        saved_col = m_col;
        saved_row = m_row;
        cyc(1'b0, 1'b0, 1'b1, 8'd55, 1'b1);
        chk("idle_sof_col", 32'(col_idx), 32'(saved_col));
        chk("idle_sof_row", 32'(row_idx), 32'(saved_row));
        check_model();

        // Reset in the middle of row 2.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, pixel_t'(120 + i), 1'b1);
        end
        chk("pre_rst_row", 32'(row_idx), 32'd2);
        cyc(1'b1, 1'b1, 1'b0, 8'd77, 1'b1);
        chk("midrst_col", 32'(col_idx), 32'd0);
        chk("midrst_row", 32'(row_idx), 32'd0);
        chk("midrst_lv", 32'(line_valid), 32'd0);
        chk("midrst_line_out", 32'(line_out), 32'd0);
        chk("midrst_eol", 32'(eol), 32'd0);
        chk("midrst_eof", 32'(eof), 32'd0);

        // Random traffic with occasional frame starts and resets.
        cyc(1'b0, 1'b1, 1'b1, pixel_t'($urandom), 1'b1);
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 39) == 0),
                pixel_t'($urandom),
                1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
